// File: rtl/hmac_stream_ctrl_pkg.sv
// hmac_ctrl_pkg: shared types and constants for the HMAC stream sequencer.
//   state_t      : sequencer states
//   PAD_BYTE     : SHA-1 message terminator byte
//   IPAD_BYTES   : HMAC block size in bytes (key is zero-filled to this)
//   after_pad80  : next state once the 0x80 word has been written at idx
package hmac_ctrl_pkg;

  typedef enum logic [3:0] {
    KEY_WAIT, KEY_FEED, KEY_DRAIN, KEY_ZERO, BUSY, MSG_FEED, PAD_80,
    PAD_ZERO, PAD_LEN_HI, PAD_LEN_LO, FIN, FIN_WAIT, DONE, NEWK, NEWM
  } state_t;

  localparam logic [7:0] PAD_BYTE   = 8'h80;
  localparam int         IPAD_BYTES = 64;
  localparam logic [3:0] LAST_IDX   = 4'(IPAD_BYTES / 4 - 1);
  localparam logic [3:0] LEN_HI_IDX = 4'(IPAD_BYTES / 4 - 2);

  // The 64-bit length needs words 14 and 15 of a block. A terminator at
  // 14 or 15 leaves no room, so an all-zero extra block follows.
  function automatic state_t after_pad80(input logic [3:0] idx);
    if (idx == LAST_IDX)            return BUSY;
    else if (idx == LEN_HI_IDX - 1) return PAD_LEN_HI;
    else                            return PAD_ZERO;
  endfunction

endpackage

// File: rtl/hmac_stream_ctrl_sha1_pad_word.sv
// sha1_pad_word: builds the final message word of a SHA-1 stream.
//   i_data   : big-endian message word, first byte in [31:24]
//   i_nbytes : valid bytes 0..4
//   o_word   : valid bytes kept, 0x80 placed right after them, rest zero
//              (nbytes=4 passes the word through unchanged)
module sha1_pad_word
  import hmac_ctrl_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_nbytes,
  output logic [31:0] o_word
);

  always_comb begin
    case (i_nbytes)
      3'd0:    o_word = {PAD_BYTE, 24'h0};
      3'd1:    o_word = {i_data[31:24], PAD_BYTE, 16'h0};
      3'd2:    o_word = {i_data[31:16], PAD_BYTE, 8'h0};
      3'd3:    o_word = {i_data[31:8], PAD_BYTE};
      default: o_word = i_data;
    endcase
  end

endmodule

// File: rtl/hmac_stream_ctrl.sv
// hmac_stream_ctrl: feeds a key stream and a message stream into hmac_core.
//   clk, nrst                       : clock, async active-low reset
//   key_valid/ready/data/last       : key words (zero-filled to 16 words)
//   msg_valid/ready/data/last/nbytes: message words, nbytes valid on last
//   core_wr/in, core_new_key, core_new_message, core_finish : core controls
//   core_idle, core_done, core_out  : core status and digest
//   mac, mac_valid                  : captured HMAC and one-cycle pulse
//   key_err                         : sticky, key longer than 16 words
module hmac_stream_ctrl
  import hmac_ctrl_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [31:0]  key_data,
  input  logic         key_last,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_nbytes,
  output logic         core_wr,
  output logic         core_new_key,
  output logic         core_new_message,
  output logic         core_finish,
  output logic [31:0]  core_in,
  input  logic         core_idle,
  input  logic         core_done,
  input  logic [159:0] core_out,
  output logic [159:0] mac,
  output logic         mac_valid,
  output logic         key_err
);

  state_t           r_state, r_ret, w_nxt, w_nxt_ret;
  logic [3:0]       r_wcnt;
  logic [LEN_W-1:0] r_len;
  logic             r_done_st;
  logic             r_bfirst;   // first BUSY cycle: core_idle not yet valid
  logic             w_key_hs, w_msg_hs, w_empty, w_part;
  logic [31:0]      w_pad_word;
  logic [63:0]      w_bitlen;

  sha1_pad_word u_pad (
    .i_data   (msg_data),
    .i_nbytes (msg_nbytes),
    .o_word   (w_pad_word)
  );

  // inner hash also covers the 64-byte ipad block
  assign w_bitlen  = (64'(r_len) + 64'(IPAD_BYTES)) << 3;

  assign key_ready = ((r_state == KEY_FEED) & core_idle) | (r_state == KEY_DRAIN);
  assign msg_ready = (r_state == MSG_FEED) & core_idle;
  assign w_key_hs  = key_valid & key_ready;
  assign w_msg_hs  = msg_valid & msg_ready;
  assign w_empty   = msg_last & (msg_nbytes == 3'd0);
  assign w_part    = msg_last & (msg_nbytes != 3'd4) & ~w_empty;

  assign core_finish      = (r_state == FIN);
  assign core_new_key     = (r_state == NEWK);
  assign core_new_message = (r_state == NEWM);

  always_comb begin
    w_nxt     = r_state;
    w_nxt_ret = r_ret;
    core_wr   = 1'b0;
    core_in   = '0;
    case (r_state)
      KEY_WAIT: if (key_valid) w_nxt = r_done_st ? NEWK : KEY_FEED;
      NEWK: begin
        w_nxt     = BUSY;
        w_nxt_ret = KEY_FEED;
      end
      KEY_FEED: begin
        core_in = key_data;
        core_wr = w_key_hs;
        if (w_key_hs) begin
          if (r_wcnt == LAST_IDX) begin
            w_nxt     = key_last ? BUSY : KEY_DRAIN;
            w_nxt_ret = MSG_FEED;
          end else if (key_last) begin
            w_nxt = KEY_ZERO;
          end
        end
      end
      KEY_DRAIN: if (key_valid & key_last) w_nxt = BUSY;
      KEY_ZERO: begin
        core_wr = core_idle;
        if (core_idle && r_wcnt == LAST_IDX) begin
          w_nxt     = BUSY;
          w_nxt_ret = MSG_FEED;
        end
      end
      BUSY: if (!r_bfirst && core_idle) w_nxt = r_ret;
      MSG_FEED: begin
        core_in = w_part ? w_pad_word : msg_data;
        core_wr = w_msg_hs & ~w_empty;
        if (w_msg_hs) begin
          if (w_empty) begin
            w_nxt = PAD_80;
          end else if (w_part) begin
            w_nxt     = after_pad80(r_wcnt);
            w_nxt_ret = PAD_ZERO;
          end else if (r_wcnt == LAST_IDX) begin
            w_nxt     = BUSY;
            w_nxt_ret = msg_last ? PAD_80 : MSG_FEED;
          end else if (msg_last) begin
            w_nxt = PAD_80;
          end
        end
      end
      PAD_80: begin
        core_in = {PAD_BYTE, 24'h0};
        core_wr = core_idle;
        if (core_idle) begin
          w_nxt     = after_pad80(r_wcnt);
          w_nxt_ret = PAD_ZERO;
        end
      end
      PAD_ZERO: begin
        core_wr = core_idle;
        if (core_idle) begin
          if (r_wcnt == LEN_HI_IDX - 1) begin
            w_nxt = PAD_LEN_HI;
          end else if (r_wcnt == LAST_IDX) begin
            w_nxt     = BUSY;
            w_nxt_ret = PAD_ZERO;
          end
        end
      end
      PAD_LEN_HI: begin
        core_in = w_bitlen[63:32];
        core_wr = core_idle;
        if (core_idle) w_nxt = PAD_LEN_LO;
      end
      PAD_LEN_LO: begin
        core_in = w_bitlen[31:0];
        core_wr = core_idle;
        if (core_idle) begin
          w_nxt     = BUSY;
          w_nxt_ret = FIN;
        end
      end
      FIN:      w_nxt = FIN_WAIT;
      FIN_WAIT: if (core_done) w_nxt = DONE;
      DONE: begin
        if (key_valid)      w_nxt = KEY_WAIT;
        else if (msg_valid) w_nxt = NEWM;
      end
      NEWM: begin
        w_nxt     = BUSY;
        w_nxt_ret = MSG_FEED;
      end
      default: w_nxt = KEY_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= KEY_WAIT;
      r_ret     <= KEY_WAIT;
      r_wcnt    <= '0;
      r_len     <= '0;
      r_done_st <= 1'b0;
      r_bfirst  <= 1'b0;
      mac       <= '0;
      mac_valid <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_ret     <= w_nxt_ret;
      r_bfirst  <= (w_nxt == BUSY) && (r_state != BUSY);
      mac_valid <= 1'b0;
      // 4-bit counter wraps 15 -> 0 at each block boundary
      if (core_wr) r_wcnt <= r_wcnt + 4'd1;
      if (w_msg_hs) r_len <= r_len + (msg_last ? LEN_W'(msg_nbytes) : LEN_W'(4));
      if (r_state == KEY_WAIT && key_valid) key_err <= 1'b0;
      if (r_state == KEY_FEED && w_key_hs && r_wcnt == LAST_IDX && !key_last)
        key_err <= 1'b1;
      if (r_state == FIN_WAIT && core_done) begin
        mac       <= core_out;
        mac_valid <= 1'b1;
        r_done_st <= 1'b1;
        r_len     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hmac_stream_ctrl.sv
// tb_hmac_stream_ctrl: drives key/message streams into hmac_stream_ctrl,
// emulates hmac_core (SHA-1 block engine with ipad/opad handling) and
// compares captured MACs with a byte-level HMAC-SHA1 reference.
module tb_hmac_stream_ctrl;

  typedef logic [7:0] bq_t[$];
  localparam logic [159:0] IV   = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [511:0] IPAD = {64{8'h36}};
  localparam logic [511:0] OPAD = {64{8'h5c}};

  logic clk = 1'b0, nrst = 1'b0;
  logic key_valid = 0, key_last = 0, msg_valid = 0, msg_last = 0;
  logic [31:0] key_data = '0, msg_data = '0;
  logic [2:0] msg_nbytes = '0;
  logic key_ready, msg_ready, core_wr, core_new_key, core_new_message, core_finish;
  logic [31:0] core_in;
  logic core_idle, core_done;
  logic [159:0] core_out, mac;
  logic mac_valid, key_err;

  int n_tests = 0, n_fail = 0;
  int n_wr_busy = 0, n_multi = 0, n_rdy_busy = 0, n_nm = 0, n_nk = 0;
  bq_t cur_key;

  always #5 clk = ~clk;

  hmac_stream_ctrl #(.LEN_W(32)) dut (
    .clk(clk), .nrst(nrst),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data), .key_last(key_last),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
    .msg_nbytes(msg_nbytes),
    .core_wr(core_wr), .core_new_key(core_new_key), .core_new_message(core_new_message),
    .core_finish(core_finish), .core_in(core_in), .core_idle(core_idle),
    .core_done(core_done), .core_out(core_out),
    .mac(mac), .mac_valid(mac_valid), .key_err(key_err)
  );

  // ---------------- SHA-1 / HMAC reference ----------------
  function automatic logic [159:0] sha1_blk(input logic [159:0] h, input logic [511:0] b);
    logic [31:0] w[80];
    logic [31:0] a, bb, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, bb, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = bb ^ c ^ d;                    k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = bb ^ c ^ d;                    k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + bb, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic logic [159:0] sha1_bytes(input bq_t m);
    bq_t q;
    logic [63:0] bits;
    logic [159:0] h;
    logic [511:0] blk;
    q = m;
    bits = 64'(m.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int i = 7; i >= 0; i--) q.push_back(bits[8*i +: 8]);
    h = IV;
    for (int o = 0; o < q.size(); o += 64) begin
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = q[o+i];
      h = sha1_blk(h, blk);
    end
    return h;
  endfunction

  // keys beyond 64 bytes are truncated, not pre-hashed
  function automatic logic [159:0] hmac_ref(input bq_t k, input bq_t m);
    bq_t a, b;
    logic [159:0] ih;
    for (int i = 0; i < 64; i++) a.push_back(((i < k.size()) ? k[i] : 8'h00) ^ 8'h36);
    foreach (m[i]) a.push_back(m[i]);
    ih = sha1_bytes(a);
    for (int i = 0; i < 64; i++) b.push_back(((i < k.size()) ? k[i] : 8'h00) ^ 8'h5c);
    for (int i = 0; i < 20; i++) b.push_back(ih[159-8*i -: 8]);
    return sha1_bytes(b);
  endfunction

  function automatic bq_t fill(input int n, input int v);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back((v < 0) ? 8'($urandom) : 8'(v));
    return q;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [511:0] put_word(input logic [511:0] b, input int idx, input logic [31:0] w);
    b[511-32*idx -: 32] = w;
    return b;
  endfunction

  // ---------------- hmac_core emulation ----------------
  int cm_cnt, cm_busy;
  logic cm_fin, cm_kph;
  logic [511:0] cm_blk, cm_key;
  logic [159:0] cm_h, cm_mac;
  logic [31:0] cm_w15;

  assign core_idle = (cm_busy == 0) && !cm_fin;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cm_cnt <= 0; cm_busy <= 0; cm_fin <= 1'b0; cm_kph <= 1'b1;
      cm_blk <= '0; cm_key <= '0; cm_h <= '0; cm_mac <= '0; cm_w15 <= '0;
      core_done <= 1'b0; core_out <= '0;
    end else begin
      core_done <= 1'b0;
      if (cm_busy != 0) cm_busy <= cm_busy - 1;
      else if (cm_fin) begin
        cm_fin <= 1'b0; core_done <= 1'b1; core_out <= cm_mac;
      end
      if (core_wr) begin
        cm_blk <= put_word(cm_blk, cm_cnt, core_in);
        cm_cnt <= (cm_cnt + 1) % 16;
        if (cm_cnt == 15) begin
          cm_w15  <= core_in;
          cm_busy <= int'($urandom_range(1, 4));
          if (cm_kph) begin
            cm_key <= put_word(cm_blk, 15, core_in);
            cm_h   <= sha1_blk(IV, put_word(cm_blk, 15, core_in) ^ IPAD);
            cm_kph <= 1'b0;
          end else begin
            cm_h <= sha1_blk(cm_h, put_word(cm_blk, 15, core_in));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          cm_busy <= 1;  // occasional mid-block stall
        end
      end
      if (core_new_key) begin
        cm_kph <= 1'b1; cm_cnt <= 0; cm_busy <= 2;
      end
      if (core_new_message) begin
        cm_h <= sha1_blk(IV, cm_key ^ IPAD); cm_cnt <= 0; cm_busy <= 2;
      end
      if (core_finish) begin
        cm_fin  <= 1'b1;
        cm_busy <= int'($urandom_range(2, 6));
        cm_mac  <= sha1_blk(sha1_blk(IV, cm_key ^ OPAD), {cm_h, 32'h80000000, 288'd0, 32'd672});
      end
    end
  end

  // protocol monitors
  always @(negedge clk) begin
    if (nrst) begin
      if (core_wr && !core_idle) n_wr_busy <= n_wr_busy + 1;
      if (32'(core_wr) + 32'(core_finish) + 32'(core_new_key) + 32'(core_new_message) > 1)
        n_multi <= n_multi + 1;
      if (msg_ready && !core_idle) n_rdy_busy <= n_rdy_busy + 1;
      if (core_new_message) n_nm <= n_nm + 1;
      if (core_new_key) n_nk <= n_nk + 1;
    end
  end

  // ---------------- checking and stimulus ----------------
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy(input bit is_msg);
    int n = 0;
    @(negedge clk);
    while (!(is_msg ? msg_ready : key_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk(is_msg ? "msg_rdy_timeout" : "key_rdy_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_key(input bq_t k);
    cur_key = k;
    for (int j = 0; j < k.size() / 4; j++) begin
      key_data  = {k[4*j], k[4*j+1], k[4*j+2], k[4*j+3]};
      key_last  = (j == k.size() / 4 - 1);
      key_valid = 1'b1;
      wait_rdy(1'b0);
      key_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_msg(input bq_t m);
    int nw, nb;
    logic [31:0] d;
    nw = (m.size() + 3) / 4;
    if (nw == 0) nw = 1;
    for (int j = 0; j < nw; j++) begin
      d  = $urandom;  // bytes past nbytes are junk the DUT must mask
      nb = (j == nw - 1) ? m.size() - 4 * j : 4;
      for (int b = 0; b < nb; b++) d[31-8*b -: 8] = m[4*j+b];
      msg_data = d; msg_last = (j == nw - 1); msg_nbytes = 3'(nb); msg_valid = 1'b1;
      wait_rdy(1'b1);
      msg_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_msg(input string tag, input bq_t m, input logic [159:0] exp);
    int n = 0;
    send_msg(m);
    @(negedge clk);
    while (!mac_valid && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk({tag, "_timeout"}, 1, 0);
    chk(tag, mac, exp);
    chk({tag, "_len"}, cm_w15, 160'((m.size() + 64) * 8));
    @(negedge clk);
    chk({tag, "_pulse"}, mac_valid, 0);
  endtask

  initial begin
    bq_t k, m, e;
    int b0;
    // reset state
    #23;
    chk("rst_ctl", {key_ready, msg_ready, core_wr, core_new_key, core_new_message,
                    core_finish, mac_valid, key_err, core_in}, 0);
    chk("rst_mac", mac, 0);
    @(posedge clk); #1; nrst = 1'b1;
    @(posedge clk); #1;

    // RFC 2202 case 1
    b0 = n_nm;
    send_key(fill(20, 8'h0b));
    m = str2q("Hi There");
    do_msg("rfc1", m, 160'hb617318655057264e28bc0b6fb378c8ef146be00);
    chk("rfc1_ref", hmac_ref(cur_key, m), 160'hb617318655057264e28bc0b6fb378c8ef146be00);
    chk("first_no_newmsg", n_nm - b0, 0);

    // RFC 2202 case 2: new key after a completed op
    b0 = n_nk;
    send_key(str2q("Jefe"));
    do_msg("rfc2", str2q("what do ya want for nothing?"),
           160'heffcdf6ae5eb2fa2d27416d5f184df9c259a7c79);
    chk("rfc2_newkey", n_nk - b0, 1);

    // RFC 2202 case 3: 0x80 merged into word 12
    send_key(fill(20, 8'haa));
    do_msg("rfc3", fill(50, 8'hdd), 160'h125d7342b9ac11cd91a39af48aa17b4f63f175d3);

    // 56 bytes: terminator at word 14, length spills into an extra block
    b0 = n_nm;
    m = fill(56, -1);
    do_msg("m56", m, hmac_ref(cur_key, m));
    chk("m56_blk2_zero", 160'(cm_blk[511:64] != '0), 0);
    chk("m56_newmsg", n_nm - b0, 1);

    // empty message, then a back-to-back message
    e = {};
    do_msg("empty", e, hmac_ref(cur_key, e));
    b0 = n_nm;
    m = fill(13, -1);
    do_msg("b2b", m, hmac_ref(cur_key, m));
    chk("b2b_newmsg", n_nm - b0, 1);

    // 17-word key: word 17 discarded, key_err sticky until next key
    k = fill(68, -1);
    send_key(k);
    @(negedge clk);
    chk("kerr_set", key_err, 1);
    m = fill(9, -1);
    do_msg("longkey", m, hmac_ref(k, m));
    chk("kerr_hold", key_err, 1);
    b0 = n_nk;
    send_key(fill(4 * $urandom_range(1, 16), -1));
    @(negedge clk);
    chk("kerr_clr", key_err, 0);
    chk("kerr_newkey", n_nk - b0, 1);

    // randomized lengths, one full 16-word key in the middle
    for (int r = 0; r < 5; r++) begin
      if (r == 2) send_key(fill(64, -1));
      m = fill($urandom_range(0, 130), -1);
      do_msg($sformatf("rnd%0d", r), m, hmac_ref(cur_key, m));
    end

    chk("wr_while_busy", n_wr_busy, 0);
    chk("multi_ctrl", n_multi, 0);
    chk("rdy_while_busy", n_rdy_busy, 0);

    // reset after activity clears captured state
    #1 nrst = 1'b0;
    #3;
    chk("rst2_mac", mac, 0);
    chk("rst2_ctl", {mac_valid, key_err, core_wr, key_ready, msg_ready}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
